// File: rtl/cpu_bus_master.sv
// NES CPU cartridge-bus initiator: free-running M2 with 2A03-style romsel/rw/address/data timing,
// fed from a one-entry request register. Optional IRQ sampling: define CPU_BUS_IRQ_SYNC_EN.
module cpu_bus_master #(
    parameter int          PHI_LO    = 4,
    parameter int          PHI_HI    = 4,
    parameter logic [15:0] IDLE_ADDR = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rw,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic        rsp_rw,
    output logic [7:0]  rsp_rdata,
    output logic        m2,
    output logic        romsel,
    output logic        cpu_rw,
    output logic [15:0] cpu_addr,
    output logic [7:0]  cpu_data_out,
    output logic        cpu_data_oe,
    input  logic [7:0]  cpu_data_in,
    input  logic        irq_n,
    output logic        irq_active
);

    localparam int PMAX = (PHI_LO > PHI_HI) ? PHI_LO : PHI_HI;
    localparam int CW   = $clog2(PMAX);
    localparam logic [CW-1:0] LO_LAST = CW'(PHI_LO - 2);
    localparam logic [CW-1:0] HI_LAST = CW'(PHI_HI - 1);

    // Handshake: a request transfers on a clk edge where req_valid & req_ready; the payload
    // must be stable while req_valid is high and req_ready low. rsp_valid is a 1-clk pulse, no backpressure.

    typedef enum logic [1:0] {LO0, LO, HI} phase_t;

    phase_t          state, state_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic            launch, rise, fall;

    logic            hold_full, hold_rw;
    logic [15:0]     hold_addr;
    logic [7:0]      hold_wdata;
    logic            cyc_host, cyc_rw;
    logic            accept;

    assign req_ready = ~hold_full;
    assign accept    = req_valid & ~hold_full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= LO0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        launch     = 1'b0;
        rise       = 1'b0;
        fall       = 1'b0;
        case (state)
            LO0: begin
                state_next = LO;
                cnt_next   = '0;
                launch     = 1'b1;
            end
            LO: begin
                if (cnt == LO_LAST) begin
                    state_next = HI;
                    cnt_next   = '0;
                    rise       = 1'b1;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            HI: begin
                if (cnt == HI_LAST) begin
                    state_next = LO0;
                    cnt_next   = '0;
                    fall       = 1'b1;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            default: begin
                state_next = LO0;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m2           <= 1'b0;
            romsel       <= 1'b1;
            cpu_rw       <= 1'b1;
            cpu_addr     <= IDLE_ADDR;
            cpu_data_out <= 8'h00;
            cpu_data_oe  <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rw       <= 1'b0;
            rsp_rdata    <= 8'h00;
            hold_full    <= 1'b0;
            hold_rw      <= 1'b1;
            hold_addr    <= 16'h0000;
            hold_wdata   <= 8'h00;
            cyc_host     <= 1'b0;
            cyc_rw       <= 1'b1;
        end else begin
            rsp_valid <= 1'b0;

            // Launch point: previous cycle's address/data were held through LO0.
            if (launch) begin
                if (hold_full) begin
                    cpu_addr    <= hold_addr;
                    cpu_rw      <= hold_rw;
                    cpu_data_oe <= ~hold_rw;
                    if (!hold_rw) begin
                        cpu_data_out <= hold_wdata;
                    end
                    cyc_host <= 1'b1;
                    cyc_rw   <= hold_rw;
                end else begin
                    cpu_addr    <= IDLE_ADDR;
                    cpu_rw      <= 1'b1;
                    cpu_data_oe <= 1'b0;
                    cyc_host    <= 1'b0;
                    cyc_rw      <= 1'b1;
                end
            end

            if (rise) begin
                m2     <= 1'b1;
                romsel <= ~cpu_addr[15];
            end

            if (fall) begin
                m2     <= 1'b0;
                romsel <= 1'b1;
                if (cyc_host) begin
                    rsp_valid <= 1'b1;
                    rsp_rw    <= cyc_rw;
                    rsp_rdata <= cyc_rw ? cpu_data_in : 8'h00;
                    cyc_host  <= 1'b0;
                end
            end

            // No bypass: a request taken on a launch edge waits for the next cycle.
            if (launch && hold_full) begin
                hold_full <= 1'b0;
            end else if (accept) begin
                hold_full  <= 1'b1;
                hold_rw    <= req_rw;
                hold_addr  <= req_addr;
                hold_wdata <= req_wdata;
            end
        end
    end

`ifdef CPU_BUS_IRQ_SYNC_EN
    logic [1:0] irq_sync;

    // Sampled only at the M2 falling edge, like the 6502's interrupt poll.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_sync   <= 2'b11;
            irq_active <= 1'b0;
        end else begin
            irq_sync <= {irq_sync[0], irq_n};
            if (fall) begin
                irq_active <= ~irq_sync[1];
            end
        end
    end
`else
    logic unused_irq_n;
    assign unused_irq_n = irq_n;
    assign irq_active   = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_bus_master.sv
// Bench for cpu_bus_master: directed bus scenarios plus random host traffic, checked every clk
// against a period/position model of the bus and an in-order response queue.
module tb_cpu_bus_master;

    localparam int          PHI_LO    = 4;
    localparam int          PHI_HI    = 4;
    localparam int          P         = PHI_LO + PHI_HI;
    localparam logic [15:0] IDLE_ADDR = 16'h0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_rw;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid, rsp_rw;
    logic [7:0]  rsp_rdata;
    logic        m2, romsel, cpu_rw;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data_out, cpu_data_in;
    logic        cpu_data_oe;
    logic        irq_n, irq_active;

    int checks = 0;
    int errors = 0;

    logic [8:0] exp_q[$];
    logic [7:0] rom [256];

    // Model state: edges since reset release, held request, current bus cycle.
    int          n = 0;
    logic        h_v = 1'b0, h_rw = 1'b1;
    logic [15:0] h_addr = 16'h0000;
    logic [7:0]  h_d = 8'h00;
    logic        c_host = 1'b0, c_rw = 1'b1;
    logic [15:0] c_addr = IDLE_ADDR;
    logic [7:0]  c_d = 8'h00;
    logic        s_valid = 1'b0, s_rw = 1'b1;
    logic [15:0] s_addr = 16'h0000;
    logic [7:0]  s_wdata = 8'h00;

    cpu_bus_master #(
        .PHI_LO(PHI_LO), .PHI_HI(PHI_HI), .IDLE_ADDR(IDLE_ADDR)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rw(rsp_rw), .rsp_rdata(rsp_rdata),
        .m2(m2), .romsel(romsel), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr),
        .cpu_data_out(cpu_data_out), .cpu_data_oe(cpu_data_oe), .cpu_data_in(cpu_data_in),
        .irq_n(irq_n), .irq_active(irq_active)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_at(input logic [15:0] a);
        return rom[a[7:0] ^ a[15:8]];
    endfunction

    assign cpu_data_in = rom_at(cpu_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Checker: processes the edge just past, using inputs snapshotted before it.
    initial begin
        int         pos;
        logic       acc_ok, exp_m2;
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (reset) begin
                n = 0; h_v = 1'b0; c_host = 1'b0; c_rw = 1'b1; c_addr = IDLE_ADDR; c_d = 8'h00;
                exp_q.delete();
            end else begin
                n++;
                pos = n % P;
                acc_ok = !h_v;
                if (pos == 1) begin
                    if (h_v) begin
                        c_host = 1'b1; c_rw = h_rw; c_addr = h_addr; c_d = h_d; h_v = 1'b0;
                    end else begin
                        c_host = 1'b0; c_rw = 1'b1; c_addr = IDLE_ADDR; c_d = 8'h00;
                    end
                end
                if (acc_ok && s_valid) begin
                    h_v = 1'b1; h_rw = s_rw; h_addr = s_addr; h_d = s_wdata;
                    exp_q.push_back({s_rw, s_rw ? rom_at(s_addr) : 8'h00});
                end
                exp_m2 = (pos >= PHI_LO);
                chk("m2", 32'(m2), 32'(exp_m2));
                chk("romsel", 32'(romsel), 32'(!(exp_m2 && c_addr[15])));
                chk("cpu_addr", 32'(cpu_addr), 32'(c_addr));
                chk("cpu_rw", 32'(cpu_rw), 32'(c_rw));
                chk("data_oe", 32'(cpu_data_oe), 32'(c_host && !c_rw));
                if (c_host && !c_rw) chk("data_out", 32'(cpu_data_out), 32'(c_d));
                chk("req_ready", 32'(req_ready), 32'(!h_v));
                chk("rsp_valid", 32'(rsp_valid), 32'(pos == 0 && c_host));
                if (rsp_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("rsp_unexpected", 32'(rsp_valid), 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_rw", 32'(rsp_rw), 32'(e[8]));
                        chk("rsp_rdata", 32'(rsp_rdata), 32'(e[7:0]));
                    end
                end
`ifndef CPU_BUS_IRQ_SYNC_EN
                chk("irq_off", 32'(irq_active), 0);
`endif
            end
            s_valid = req_valid; s_rw = req_rw; s_addr = req_addr; s_wdata = req_wdata;
        end
    end

    task automatic idle(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic rw, input logic [15:0] a, input logic [7:0] d);
        logic acc;
        int   t;
        req_valid = 1'b1; req_rw = rw; req_addr = a; req_wdata = d;
        t = 0;
        do begin
            acc = req_ready;
            idle(1);
            t++;
        end while (!acc && t < 64);
        chk("accept_timeout", 32'(acc), 1);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || h_v) && t < 8 * P) begin
            idle(1);
            t++;
        end
        chk("drain", 32'(exp_q.size()), 0);
    endtask

    task automatic wait_edge(input logic want_rise);
        logic prev, found;
        int   t;
        prev = m2; found = 1'b0; t = 0;
        while (!found && t < 4 * P) begin
            idle(1);
            t++;
            found = want_rise ? (!prev && m2) : (prev && !m2);
            prev = m2;
        end
        chk(want_rise ? "rise_timeout" : "fall_timeout", 32'(found), 1);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_m2"}, 32'(m2), 0);
        chk({tag, "_romsel"}, 32'(romsel), 1);
        chk({tag, "_cpu_rw"}, 32'(cpu_rw), 1);
        chk({tag, "_cpu_addr"}, 32'(cpu_addr), 32'(IDLE_ADDR));
        chk({tag, "_data_out"}, 32'(cpu_data_out), 0);
        chk({tag, "_data_oe"}, 32'(cpu_data_oe), 0);
        chk({tag, "_req_ready"}, 32'(req_ready), 1);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        chk({tag, "_irq"}, 32'(irq_active), 0);
    endtask

    initial begin
        logic        rw;
        logic [15:0] a;
        reset = 1'b1; irq_n = 1'b1;
        req_valid = 1'b0; req_rw = 1'b1; req_addr = 16'h0000; req_wdata = 8'h00;
        foreach (rom[i]) rom[i] = 8'($urandom);
        rom[8'hC0] = 8'hA5;
        #1;
        check_reset_values("rst");
        chk("rst_rdata", 32'(rsp_rdata), 0);
        @(negedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;

        // Idle: 100 bus periods of dummy reads.
        idle(100 * P);

        send(1'b0, 16'h6000, 8'h83);
        drain();
        send(1'b1, 16'hC000, 8'h00);
        drain();

        send(1'b0, 16'h6001, 8'h85);
        send(1'b1, 16'h8000, 8'h00);
        send(1'b1, 16'hFFFC, 8'h00);
        drain();

        // Reset while a write is on the bus and another is held.
        send(1'b0, 16'h6002, 8'h11);
        send(1'b0, 16'h6003, 8'h22);
        wait_edge(1'b1);
        idle(1);
        reset = 1'b1;
        #1;
        check_reset_values("midrst");
        @(negedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;
        idle(4 * P);
        chk("midrst_q", 32'(exp_q.size()), 0);

        // IRQ: pull low mid-HI, release mid-LO.
        wait_edge(1'b1);
        idle(1);
        irq_n = 1'b0;
`ifdef CPU_BUS_IRQ_SYNC_EN
        chk("irq_before", 32'(irq_active), 0);
        begin
            int f = 0;
            while (f < 2 && !irq_active) begin
                wait_edge(1'b0);
                f++;
            end
        end
        chk("irq_set", 32'(irq_active), 1);
`else
        wait_edge(1'b0);
        wait_edge(1'b0);
`endif
        idle(2);
        irq_n = 1'b1;
        wait_edge(1'b0);
`ifdef CPU_BUS_IRQ_SYNC_EN
        chk("irq_clr", 32'(irq_active), 0);
`endif

        for (int i = 0; i < 150; i++) begin
            rw = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0:       a = 16'h6000 | 16'($urandom_range(0, 255));
                1:       a = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
                default: a = 16'($urandom);
            endcase
            send(rw, a, 8'($urandom));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 20));
        end
        drain();
        idle(2 * P);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_bus_master.md
Name: cpu_bus_master

Overview:
- Console-side initiator for the NES CPU cartridge bus.
- Generates a free-running M2 clock plus romsel, cpu_rw, address and data exactly as the 2A03 presents them. Mapper register writes, PRG reads and the IRQ line can then be exercised from a host/test FPGA.
- Sits between a simple request/response port (host logic, flash dumper/programmer) and the cartridge edge connector.
- Idle bus cycles are dummy reads, so M2-counted mapper logic (IRQ timers) keeps running.

Parameters:
- PHI_LO, 4, clk cycles per bus cycle with m2 low; minimum 2.
- PHI_HI, 4, clk cycles per bus cycle with m2 high; minimum 1.
- IDLE_ADDR, 16'h0000, address driven on dummy-read cycles; romsel stays high when bit 15 = 0.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  host request present
- req_ready  out  1  holding register empty; request accepted when req_valid & req_ready
- req_rw  in  1  1 = read, 0 = write
- req_addr  in  16  CPU address
- req_wdata  in  8  write data
- rsp_valid  out  1  one-clk pulse when a host bus cycle completes
- rsp_rw  out  1  rw of the completed cycle
- rsp_rdata  out  8  read data; 8'h00 for writes
- m2  out  1  CPU M2 / phi2
- romsel  out  1  active low: addr[15] & m2
- cpu_rw  out  1  bus direction
- cpu_addr  out  16  bus address
- cpu_data_out  out  8  write data
- cpu_data_oe  out  1  drive enable for cpu_data_out
- cpu_data_in  in  8  bus data from cartridge
- irq_n  in  1  cartridge IRQ, open-drain, active low
- irq_active  out  1  synchronized IRQ, see Optional Feature

Behaviour:
- Reset values:
  - m2 = 0, romsel = 1, cpu_rw = 1, cpu_addr = IDLE_ADDR
  - cpu_data_out = 0, cpu_data_oe = 0
  - req_ready = 1, rsp_valid = 0, rsp_rdata = 0, irq_active = 0
  - phase counter = 0, state = LO0
- Phase sequencer, repeating forever:
  - LO0: 1 clk, m2 = 0.
  - LO: PHI_LO-1 clks, m2 = 0.
  - HI: PHI_HI clks, m2 = 1.
  - Total bus period = PHI_LO + PHI_HI clks. M2 never stops, including while the host is idle.
- m2 falls on the clk entering LO0.
  - Address, rw and data from the previous cycle are held through LO0. This gives 1 clk of hold after the M2 falling edge, since mappers sample on negedge m2.
- At the clk entering LO (LO0 + 1), the next cycle is launched:
  - If the holding register is full: cpu_addr = held addr, cpu_rw = held rw. For a write, cpu_data_out = held data and cpu_data_oe = 1. Holding register becomes empty, so req_ready = 1 from the next clk.
  - Otherwise: dummy read with cpu_addr = IDLE_ADDR, cpu_rw = 1, cpu_data_oe = 0.
- romsel goes low in the same clk m2 rises, when cpu_addr[15] = 1. It returns high in the same clk m2 falls.
- cpu_data_oe for a write stays asserted through LO0 of the following cycle, then drops at the LO launch unless the next cycle is also a write.
- Completion, host cycles only, never dummy cycles:
  - On the clk m2 falls, a read registers cpu_data_in into rsp_rdata.
  - rsp_valid pulses for exactly 1 clk, in the clk after m2 falls, together with rsp_rw.
- Host handshake:
  - One-entry holding register. req_ready = !full.
  - A request accepted in the same clk as a launch goes to the next cycle. There is no bypass.
  - Requests accepted back to back run in consecutive bus cycles with no dummy cycle between them.
  - Response order equals request order.
  - Latency from accept to rsp_valid: at most 2 bus periods + 1 clk.
- Phase counter width = clog2(max(PHI_LO, PHI_HI)). It wraps only via state transitions, never by overflow.
- Reset asserted mid-cycle:
  - All outputs return to reset values immediately, because reset is asynchronous.
  - A held or in-flight request is discarded with no rsp_valid.
  - After reset is released, the sequencer restarts at LO0.

Optional Feature:
- Macro: CPU_BUS_IRQ_SYNC_EN
- Defined:
  - irq_n passes through a 2-flop synchronizer on clk.
  - irq_active samples the synchronized inverse of irq_n on each clk where m2 falls, mirroring the 6502 polling point.
  - irq_active holds its value between samples.
- Undefined: irq_active is tied 0 and irq_n is ignored.

Test Plan:
- Idle after reset, defaults (4/4): m2 period is 8 clk with 50% duty. cpu_addr = 16'h0000, romsel constantly 1, cpu_rw = 1, no rsp_valid over 100 periods.
- Write req_addr = 16'h6000, req_wdata = 8'h83: in the next cycle cpu_rw = 0, cpu_data_oe = 1 and cpu_data_out = 8'h83 from LO through LO0 of the following cycle, romsel stays 1. rsp_valid pulses once with rsp_rw = 0 and rsp_rdata = 8'h00.
- Read 16'hC000 with cpu_data_in = 8'hA5: romsel = 0 exactly during the m2-high clks. rsp_rdata = 8'hA5 with a one-clk rsp_valid in the clk after m2 falls.
- Three back-to-back requests (write 16'h6001 = 8'h85, read 16'h8000, read 16'hFFFC): three consecutive bus cycles, no dummy cycle between them, responses in order, req_ready low while the register is full.
- Assert reset during the HI phase of a pending write: outputs return to reset values in the same clk, no rsp_valid. After release, m2 restarts low and the write is never issued.
- With CPU_BUS_IRQ_SYNC_EN, drive irq_n low mid-HI: irq_active = 1 at the second m2 falling edge at the latest, and it clears one m2 falling edge after irq_n is released. Without the macro, irq_active stays 0.
